// File: rtl/ras_ckpt_stack.sv
// ras_ckpt_stack: circular return-address stack with speculative checkpoint restore
module ras_ckpt_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int CKPTS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data,
  input  logic                       ckpt_save,
  input  logic [$clog2(CKPTS)-1:0]   ckpt_wid,
  input  logic                       ckpt_restore,
  input  logic [$clog2(CKPTS)-1:0]   ckpt_rid,
  output logic [WIDTH-1:0]           top,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       udf
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] ONE = 1;
  localparam logic [PW:0] CONE = 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] c_top [CKPTS];
  logic [PW-1:0]    c_ptr [CKPTS];
  logic [PW:0]      c_cnt [CKPTS];
  logic [PW-1:0]    ptr, ptr_m1, r_idx;
  logic [PW:0]      cnt;
  assign ptr_m1 = ptr - ONE;
  assign r_idx  = c_ptr[ckpt_rid] - ONE;
  assign top    = (cnt != '0) ? stack[ptr_m1] : '0;
  assign empty  = cnt == '0;
  assign count  = cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      for (int i = 0; i < CKPTS; i++) begin
        c_top[i] <= '0;
        c_ptr[i] <= '0;
        c_cnt[i] <= '0;
      end
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (!stall) begin
      ovf <= 1'b0;
      udf <= 1'b0;
      if (ckpt_restore) begin
        ptr <= c_ptr[ckpt_rid];
        cnt <= c_cnt[ckpt_rid];
        if (c_cnt[ckpt_rid] != '0) stack[r_idx] <= c_top[ckpt_rid];
      end else begin
        if (ckpt_save) begin
          c_ptr[ckpt_wid] <= ptr;
          c_cnt[ckpt_wid] <= cnt;
          c_top[ckpt_wid] <= top;
        end
        if (push && pop && cnt != '0) stack[ptr_m1] <= data;
        else if (push) begin
          stack[ptr] <= data;
          ptr <= ptr + ONE;
          if (cnt == FULL) ovf <= 1'b1;
          else cnt <= cnt + CONE;
        end else if (pop) begin
          if (cnt != '0) begin
            ptr <= ptr_m1;
            cnt <= cnt - CONE;
          end else udf <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_ras_ckpt_stack.sv
// tb_ras_ckpt_stack: scoreboard bench, stimulus queues expectations and a monitor checks them
module tb_ras_ckpt_stack;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0, push = 1'b0, pop = 1'b0;
  logic ckpt_save = 1'b0, ckpt_restore = 1'b0, chk = 1'b0;
  logic [31:0] data = '0, top;
  logic [1:0] ckpt_wid = '0, ckpt_rid = '0;
  logic [2:0] count;
  logic empty, ovf, udf;
  int tests = 0, fails = 0;
  typedef struct {
    string       name;
    logic [31:0] top;
    logic [2:0]  cnt;
    logic        emp, ovf, udf;
  } exp_t;
  exp_t q[$];
  ras_ckpt_stack #(.DEPTH(4), .WIDTH(32), .CKPTS(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .push(push), .pop(pop), .data(data),
    .ckpt_save(ckpt_save), .ckpt_wid(ckpt_wid), .ckpt_restore(ckpt_restore),
    .ckpt_rid(ckpt_rid), .top(top), .empty(empty), .count(count), .ovf(ovf), .udf(udf)
  );
  always #5 clk = ~clk;
  always begin
    @(posedge clk or posedge chk);
    #2;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if ({top, count, empty, ovf, udf} !== {e.top, e.cnt, e.emp, e.ovf, e.udf}) begin
        fails++;
        $display("FAIL %s: got top=%h count=%0d empty=%b ovf=%b udf=%b, want top=%h count=%0d empty=%b ovf=%b udf=%b",
                 e.name, top, count, empty, ovf, udf, e.top, e.cnt, e.emp, e.ovf, e.udf);
      end
    end
  end
  task automatic expect_state(input string n, input logic [31:0] t, input logic [2:0] c,
                              input logic o, input logic u);
    exp_t e;
    e.name = n; e.top = t; e.cnt = c; e.emp = (c == 3'd0); e.ovf = o; e.udf = u;
    q.push_back(e);
  endtask
  task automatic step(input string n, input logic pu, input logic po, input logic [31:0] d,
                      input logic sv, input logic [1:0] wid, input logic rs, input logic [1:0] rid,
                      input logic st, input logic [31:0] t, input logic [2:0] c,
                      input logic o, input logic u);
    @(negedge clk);
    push = pu; pop = po; data = d; ckpt_save = sv; ckpt_wid = wid;
    ckpt_restore = rs; ckpt_rid = rid; stall = st;
    expect_state(n, t, c, o, u);
    @(posedge clk);
    #1;
    push = 0; pop = 0; data = '0; ckpt_save = 0; ckpt_wid = '0;
    ckpt_restore = 0; ckpt_rid = '0; stall = 0;
  endtask
  task automatic op(input string n, input logic pu, input logic po, input logic [31:0] d,
                    input logic [31:0] t, input logic [2:0] c, input logic o, input logic u);
    step(n, pu, po, d, 0, 2'd0, 0, 2'd0, 0, t, c, o, u);
  endtask
  task automatic check_now(input string n, input logic [31:0] t, input logic [2:0] c);
    expect_state(n, t, c, 0, 0);
    chk = 1'b1;
    #3 chk = 1'b0;
  endtask
  initial begin
    #1 check_now("reset_state", 32'h0, 3'd0);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    op("lifo_push1", 1, 0, 32'h100, 32'h100, 3'd1, 0, 0);
    op("lifo_push2", 1, 0, 32'h200, 32'h200, 3'd2, 0, 0);
    op("lifo_push3", 1, 0, 32'h300, 32'h300, 3'd3, 0, 0);
    op("lifo_pop1",  0, 1, 32'h0,   32'h200, 3'd2, 0, 0);
    op("lifo_pop2",  0, 1, 32'h0,   32'h100, 3'd1, 0, 0);
    op("lifo_pop3",  0, 1, 32'h0,   32'h0,   3'd0, 0, 0);
    op("ovf_push1",  1, 0, 32'hA1,  32'hA1,  3'd1, 0, 0);
    op("ovf_push2",  1, 0, 32'hA2,  32'hA2,  3'd2, 0, 0);
    op("ovf_push3",  1, 0, 32'hA3,  32'hA3,  3'd3, 0, 0);
    op("ovf_push4",  1, 0, 32'hA4,  32'hA4,  3'd4, 0, 0);
    op("ovf_push5",  1, 0, 32'hA5,  32'hA5,  3'd4, 1, 0);
    op("ovf_clear",  0, 0, 32'h0,   32'hA5,  3'd4, 0, 0);
    op("ovf_pop1",   0, 1, 32'h0,   32'hA4,  3'd3, 0, 0);
    op("ovf_pop2",   0, 1, 32'h0,   32'hA3,  3'd2, 0, 0);
    op("ovf_pop3",   0, 1, 32'h0,   32'hA2,  3'd1, 0, 0);
    op("ovf_pop4",   0, 1, 32'h0,   32'h0,   3'd0, 0, 0);
    op("udf_pop",    0, 1, 32'h0,   32'h0,   3'd0, 0, 1);
    op("udf_clear",  0, 0, 32'h0,   32'h0,   3'd0, 0, 0);
    op("rep_push1",  1, 0, 32'h10,  32'h10,  3'd1, 0, 0);
    op("rep_push2",  1, 0, 32'h20,  32'h20,  3'd2, 0, 0);
    op("rep_replace",1, 1, 32'h99,  32'h99,  3'd2, 0, 0);
    op("rep_pop1",   0, 1, 32'h0,   32'h10,  3'd1, 0, 0);
    op("rep_pop2",   0, 1, 32'h0,   32'h0,   3'd0, 0, 0);
    op("pp_empty",   1, 1, 32'h44,  32'h44,  3'd1, 0, 0);
    op("pp_pop",     0, 1, 32'h0,   32'h0,   3'd0, 0, 0);
    op("ck_push1",   1, 0, 32'h10,  32'h10,  3'd1, 0, 0);
    op("ck_push2",   1, 0, 32'h20,  32'h20,  3'd2, 0, 0);
    step("ck_save1", 0, 0, 32'h0, 1, 2'd1, 0, 2'd0, 0, 32'h20, 3'd2, 0, 0);
    op("ck_pop",     0, 1, 32'h0,   32'h10,  3'd1, 0, 0);
    op("ck_push77",  1, 0, 32'h77,  32'h77,  3'd2, 0, 0);
    op("ck_push88",  1, 0, 32'h88,  32'h88,  3'd3, 0, 0);
    step("ck_restore1", 0, 0, 32'h0, 0, 2'd0, 1, 2'd1, 0, 32'h20, 3'd2, 0, 0);
    op("ck_pop_after", 0, 1, 32'h0, 32'h10,  3'd1, 0, 0);
    step("save_and_push", 1, 0, 32'h55, 1, 2'd3, 0, 2'd0, 0, 32'h55, 3'd2, 0, 0);
    step("restore3", 0, 0, 32'h0, 0, 2'd0, 1, 2'd3, 0, 32'h10, 3'd1, 0, 0);
    step("restore_drops_push", 1, 0, 32'hAA, 0, 2'd0, 1, 2'd3, 0, 32'h10, 3'd1, 0, 0);
    op("push_after_restore", 1, 0, 32'hBB, 32'hBB, 3'd2, 0, 0);
    step("stall_all", 1, 1, 32'hCC, 1, 2'd2, 0, 2'd0, 1, 32'hBB, 3'd2, 0, 0);
    step("restore_unsaved", 0, 0, 32'h0, 0, 2'd0, 1, 2'd2, 0, 32'h0, 3'd0, 0, 0);
    op("udf_again",  0, 1, 32'h0,   32'h0,   3'd0, 0, 1);
    step("stall_holds_udf", 0, 1, 32'h0, 0, 2'd0, 0, 2'd0, 1, 32'h0, 3'd0, 0, 1);
    op("udf_drop",   0, 0, 32'h0,   32'h0,   3'd0, 0, 0);
    op("fill1",      1, 0, 32'h1,   32'h1,   3'd1, 0, 0);
    op("fill2",      1, 0, 32'h2,   32'h2,   3'd2, 0, 0);
    op("fill3",      1, 0, 32'h3,   32'h3,   3'd3, 0, 0);
    op("fill4",      1, 0, 32'h4,   32'h4,   3'd4, 0, 0);
    @(negedge clk);
    push = 1'b1; data = 32'hEE;
    #1 reset = 1'b0;
    check_now("async_reset", 32'h0, 3'd0);
    push = 1'b0; data = '0;
    @(negedge clk) reset = 1'b1;
    op("push_after_reset", 1, 0, 32'h5, 32'h5, 3'd1, 0, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
